// File: rtl/mulf_sp.sv
// Binary32 floating-point multiplier: single-cycle combinational core with a registered result stage.
// Denormal operands are treated as zero and results never come out denormal.
module mulf_sp (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] s,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic [23:0] smant,
  output logic [7:0]  sexp
);

  logic              sign;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic signed [9:0] exp_sum, exp_n, exp_f;
  logic [23:0]       mant_n, mant_f;
  logic [24:0]       mant_r;
  logic              guard, sticky, round_up;

  logic [31:0]       s_d;
  logic              ovf_d, unf_d, inv_d;
  logic [23:0]       smant_d;
  logic [7:0]        sexp_d;

  assign sign   = a[31] ^ b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign fa     = a[22:0];
  assign fb     = b[22:0];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hff) && (fb != 23'd0);

  assign prod    = {1'b1, fa} * {1'b1, fb};
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  always_comb begin
    if (prod[47]) begin
      mant_n = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_sum + 10'sd1;
    end else begin
      mant_n = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_sum;
    end
  end

  // Round to nearest, ties to even; a carry out renormalises by one place.
  assign round_up = guard & (sticky | mant_n[0]);
  assign mant_r   = {1'b0, mant_n} + {24'd0, round_up};

  always_comb begin
    if (mant_r[24]) begin
      mant_f = mant_r[24:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      mant_f = mant_r[23:0];
      exp_f  = exp_n;
    end
  end

  always_comb begin
    s_d     = {sign, 31'd0};
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    inv_d   = 1'b0;
    smant_d = 24'd0;
    sexp_d  = 8'd0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s_d    = {sign, 31'h7fc00000};
      inv_d  = 1'b1;
      sexp_d = 8'hff;
    end else if (a_inf || b_inf) begin
      s_d    = {sign, 8'hff, 23'd0};
      sexp_d = 8'hff;
    end else if (a_zero || b_zero) begin
      s_d = {sign, 31'd0};
    end else if (exp_f >= 10'sd255) begin
      s_d    = {sign, 8'hff, 23'd0};
      ovf_d  = 1'b1;
      sexp_d = 8'hff;
    end else if (exp_f <= 10'sd0) begin
      s_d   = {sign, 31'd0};
      unf_d = 1'b1;
    end else begin
      smant_d = mant_f;
      sexp_d  = exp_f[7:0];
      s_d     = {sign, exp_f[7:0], mant_f[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
      smant     <= 24'd0;
      sexp      <= 8'd0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s         <= s_d;
        overflow  <= ovf_d;
        underflow <= unf_d;
        invalid   <= inv_d;
        smant     <= smant_d;
        sexp      <= sexp_d;
      end
    end
  end

endmodule

// File: tb/tb_mulf_sp.sv
// Self-checking bench for mulf_sp: directed cases plus random operands against an
// arithmetic reference model of binary32 multiplication.
module tb_mulf_sp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] s;
  logic        overflow, underflow, invalid;
  logic [23:0] smant;
  logic [7:0]  sexp;

  int total = 0;
  int bad   = 0;

  logic        e_v;
  logic [31:0] e_s;
  logic [2:0]  e_f;
  logic [23:0] e_m;
  logic [7:0]  e_e;

  mulf_sp dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .s(s), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .smant(smant), .sexp(sexp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: exact integer product, then round the dropped tail to nearest/even by value.
  task automatic model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] rs,
                       output logic [2:0] rf, output logic [23:0] rm, output logic [7:0] re);
    int ex, ey, e, sh;
    longint unsigned p, q, rem, half;
    bit sg, xz, yz, xi, yi, xn, yn;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    rs = {sg, 31'd0};
    rf = 3'b000;
    rm = 24'd0;
    re = 8'd0;
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      rs = {sg, 31'h7fc00000};
      rf = 3'b001;
      re = 8'hff;
    end else if (xi || yi) begin
      rs = {sg, 8'hff, 23'd0};
      re = 8'hff;
    end else if (!(xz || yz)) begin
      p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e  = ex + ey - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = e + sh - 23;
      q  = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        rs = {sg, 8'hff, 23'd0};
        rf = 3'b100;
        re = 8'hff;
      end else if (e <= 0) begin
        rf = 3'b010;
      end else begin
        rm = q[23:0];
        re = e[7:0];
        rs = {sg, re, rm[22:0]};
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output against expectation.
  task automatic step(input logic r, input logic v, input logic [31:0] ta, input logic [31:0] tb);
    logic [31:0] ms;
    logic [2:0]  mf;
    logic [23:0] mm;
    logic [7:0]  me;
    rst = r;
    in_valid = v;
    a = ta;
    b = tb;
    model(ta, tb, ms, mf, mm, me);
    @(posedge clk);
    #1;
    if (r) begin
      e_v = 1'b0; e_s = 32'd0; e_f = 3'b000; e_m = 24'd0; e_e = 8'd0;
    end else begin
      e_v = v;
      if (v) begin
        e_s = ms; e_f = mf; e_m = mm; e_e = me;
      end
    end
    check("out_valid", {31'd0, out_valid}, {31'd0, e_v});
    check("s", s, e_s);
    check("flags", {29'd0, overflow, underflow, invalid}, {29'd0, e_f});
    check("smant", {8'd0, smant}, {8'd0, e_m});
    check("sexp", {24'd0, sexp}, {24'd0, e_e});
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       r[30:0] = 31'd0;
      1:       r[30:0] = {8'hff, 23'd0};
      2:       r[30:23] = 8'hff;
      3:       r[30:23] = 8'($urandom_range(1, 8));
      4:       r[30:23] = 8'($urandom_range(246, 254));
      5:       r[30:23] = 8'($urandom_range(60, 70));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    if (k == 2 && r[22:0] == 23'd0) r[0] = 1'b1;
    return r;
  endfunction

  logic [31:0] da [11] = '{32'h3F800000, 32'hC0A00000, 32'hC0400000, 32'h7F000000, 32'h00800000,
                           32'h80800000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h80000000,
                           32'h3FFFFFFF};
  logic [31:0] db [11] = '{32'h40A00000, 32'h40400000, 32'hC0666666, 32'h7F000000, 32'h3F000000,
                           32'h3F000000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h40400000,
                           32'h3F800001};
  logic [31:0] ds [11] = '{32'h40A00000, 32'hC1700000, 32'h412CCCCC, 32'h7F800000, 32'h00000000,
                           32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
                           32'h40000000};
  logic [2:0]  df [11] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010,
                           3'b010, 3'b001, 3'b000, 3'b001, 3'b000,
                           3'b000};

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000;
    e_v = 1'b0; e_s = 32'd0; e_f = 3'b000; e_m = 24'd0; e_e = 8'd0;
    #2;
    step(1'b1, 1'b1, 32'h3F800000, 32'h40000000);
    step(1'b1, 1'b1, 32'h40400000, 32'h40400000);

    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, da[i], db[i]);
      check("dir_s", s, ds[i]);
      check("dir_flags", {29'd0, overflow, underflow, invalid}, {29'd0, df[i]});
      if (i == 2) begin
        check("tie_smant", {8'd0, smant}, 32'h00ACCCCC);
        check("tie_sexp", {24'd0, sexp}, 32'h00000082);
      end
      if (i == 2) step(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0);
    end

    step(1'b0, 1'b1, 32'h40000000, 32'h40400000);
    step(1'b0, 1'b0, 32'h41200000, 32'h41200000);
    check("hold_s", s, 32'h40C00000);
    step(1'b0, 1'b1, 32'h41200000, 32'h41200000);
    check("resume_s", s, 32'h42C80000);

    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), rand_op(), rand_op());
    end

    step(1'b0, 1'b1, 32'h40400000, 32'h40400000);
    step(1'b1, 1'b1, 32'h40400000, 32'h40400000);
    check("midrst_s", s, 32'h00000000);
    step(1'b0, 1'b1, 32'h3F800000, 32'hBF800000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
